systolic_operand_feeder: RTL and testbench
==========================================

Name: systolic_operand_feeder

Overview:
- Writer side for the systolic matrix multiplier's per-row A and per-column B operand inputs.
- Accepts one K-deep tile of operands over a valid/ready load stream and buffers it internally.
- Replays the tile into the array as diagonally skewed wavefronts: row i delayed i cycles, column j delayed j cycles.
- Pulses an accumulator clear before the wavefronts and a done strobe once the last product has reached PE (M-1,N-1).

Parameters:
- M, 4, array rows (A lanes)
- N, 4, array columns (B lanes)
- K, 4, inner dimension (beats per tile)
- DW, 16, operand element width

Ports:
- clk  input  1  clock; all flops rise-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  load beat valid.
- in_ready  output  1  load beat accepted when in_valid && in_ready.
- in_a  input  M*DW  beat k: lane i bits [i*DW +: DW] = A[i][k].
- in_b  input  N*DW  beat k: lane j bits [j*DW +: DW] = B[k][j].
- a_out  output  M*DW  skewed A lanes to array, registered.
- b_out  output  N*DW  skewed B lanes to array, registered.
- acc_clr  output  1  one-cycle accumulator clear to array.
- feed_active  output  1  high during FEED.
- done  output  1  one-cycle tile-complete strobe.
- tile_count  output  32  completed tiles (see Optional Feature).

Behaviour:
- Reset (async, any state): state=LOAD, load and feed counters=0. Outputs: in_ready=1, a_out=0, b_out=0, acc_clr=0, feed_active=0, done=0, tile_count=0. Buffer contents are not cleared and are don't-care.
- States: LOAD -> CLR -> FEED -> DONE -> LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes column k of A and row k of B; k increments.
  - in_valid low holds k.
  - On acceptance of beat K-1, k returns to 0 and the next state is CLR.
- CLR: one cycle; acc_clr=1, in_ready=0.
- FEED:
  - T = K+M+N-2 cycles, feed counter t=0..T-1; feed_active=1, in_ready=0.
  - a_out lane i = A[i][t-i] if 0<=t-i<K, else 0.
  - b_out lane j = B[t-j][j] if 0<=t-j<K, else 0.
  - The zero tail lets the final partial sums settle.
- DONE: one cycle; done=1, a_out=b_out=0, in_ready=0; next state LOAD.
- Timing: last beat accepted in cycle c -> acc_clr in c+1, FEED in c+2..c+T+1, done in c+T+2, in_ready=1 from c+T+3.
- a_out and b_out are 0 in every cycle outside FEED.
- Beats presented while in_ready=0 are not consumed; the source holds them.
- No back-pressure from the array: the feed is fixed-rate.
- Reset during any state aborts the tile. No done strobe and no tile_count increment for the aborted tile. The next load starts at beat 0.
- Element arithmetic: none; pure data movement. Width is DW end to end.

Optional Feature:
- Macro: FEEDER_TILE_CNT_EN.
- Defined: tile_count is a 32-bit counter, incremented in the DONE cycle. It wraps from 0xFFFFFFFF to 0 and is cleared only by rst.
- Undefined: tile_count is tied to 0 and no counter flops exist.

Test Plan:
- Reset with in_valid=1 -> all outputs 0 and in_ready=1 while rst is high; no beat is captured until rst falls.
- M=N=K=4, A[i][k]=4i+k+1, B[k][j]=16+4k+j loaded in 4 back-to-back beats -> FEED t=3: a_out lanes {4,7,10,13}, b_out lanes {28,25,22,19}. t=0: a lane0=1, others 0. t=9: all lanes 0.
- Same load, last beat accepted in cycle c -> acc_clr only at c+1, feed_active c+2..c+11 (10 cycles), done only at c+12, in_ready high at c+13.
- in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats captured, in order. in_valid held high through FEED -> in_ready=0 and no capture until back in LOAD.
- rst pulsed at FEED t=5 -> outputs 0 on rst assertion, no done. A fresh 4-beat load then produces a correct tile with the new data.
- Two complete tiles with FEEDER_TILE_CNT_EN defined -> tile_count=1 after the first done and 2 after the second. Built without the macro -> tile_count stays 0.

Source files
------------

// File: rtl/systolic_operand_feeder.sv
// Buffers one K-deep operand tile and replays it into a systolic array as skewed A/B wavefronts.
// Optional FEEDER_TILE_CNT_EN macro enables the 32-bit completed-tile counter on tile_count.
module systolic_operand_feeder #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [M*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic            acc_clr,
  output logic            feed_active,
  output logic            done,
  output logic [31:0]     tile_count
);
  localparam int T  = K + M + N - 2;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = $clog2(T + 1);

  // Load handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // the source must hold in_a/in_b stable while in_valid is high and in_ready is low.
  typedef enum logic [1:0] {S_LOAD, S_CLR, S_FEED, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k_cnt, k_nxt;
  logic [TW-1:0]   t_cnt, t_nxt;
  logic [M*DW-1:0] a_nxt;
  logic [N*DW-1:0] b_nxt;
  logic            accept;
  int              d;

  logic [DW-1:0] a_buf [M][K];
  logic [DW-1:0] b_buf [K][N];

  assign accept = (state == S_LOAD) && in_valid;

  always_comb begin
    state_nxt   = state;
    k_nxt       = k_cnt;
    t_nxt       = '0;
    in_ready    = 1'b0;
    acc_clr     = 1'b0;
    feed_active = 1'b0;
    done        = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (k_cnt == KW'(K - 1)) begin
            k_nxt     = '0;
            state_nxt = S_CLR;
          end else begin
            k_nxt = k_cnt + 1'b1;
          end
        end
      end
      S_CLR: begin
        acc_clr   = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        feed_active = 1'b1;
        if (t_cnt == TW'(T - 1)) state_nxt = S_DONE;
        else                     t_nxt     = t_cnt + 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Operand registers are loaded with the value for the cycle being entered,
  // so lane i shows A[i][t-i] exactly during FEED cycle t.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    d     = 0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < M; i++) begin
        d = int'(t_nxt) - i;
        if (d >= 0 && d < K) a_nxt[i*DW +: DW] = a_buf[i][d[KW-1:0]];
      end
      for (int j = 0; j < N; j++) begin
        d = int'(t_nxt) - j;
        if (d >= 0 && d < K) b_nxt[j*DW +: DW] = b_buf[d[KW-1:0]][j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      k_cnt <= '0;
      t_cnt <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      state <= state_nxt;
      k_cnt <= k_nxt;
      t_cnt <= t_nxt;
      a_out <= a_nxt;
      b_out <= b_nxt;
    end
  end

  // Tile storage carries no reset; any write during reset lands in column 0,
  // which beat 0 of the next load overwrites.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < M; i++) a_buf[i][k_cnt] <= in_a[i*DW +: DW];
      for (int j = 0; j < N; j++) b_buf[k_cnt][j] <= in_b[j*DW +: DW];
    end
  end

`ifdef FEEDER_TILE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tile_count <= '0;
    else if (state == S_DONE) tile_count <= tile_count + 32'd1;
  end
`else
  assign tile_count = '0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder: directed vector table, load patterns,
// reset abort and randomized tiles checked against a matrix-level skew model.
module tb_systolic_operand_feeder;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 16;
  localparam int T  = K + M + N - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [M*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic [M*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic            acc_clr;
  logic            feed_active;
  logic            done;
  logic [31:0]     tile_count;

  systolic_operand_feeder #(.M(M), .N(N), .K(K), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a_out(a_out), .b_out(b_out),
    .acc_clr(acc_clr), .feed_active(feed_active), .done(done),
    .tile_count(tile_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tiles_done = 0;

  logic [DW-1:0]   cur_a [M][K];
  logic [DW-1:0]   cur_b [K][N];
  logic [M*DW-1:0] exp_q [$];
  logic [N*DW-1:0] exp_b_q [$];
  logic [M*DW-1:0] seen_a [T];
  logic [N*DW-1:0] seen_b [T];

  typedef struct {
    int          t;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;
  vec_t vecs [5];

  // reference model: spec skew rule evaluated straight from the matrices
  function automatic logic [M*DW-1:0] model_a(input int t);
    logic [M*DW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      if (t - i >= 0 && t - i < K) r[i*DW +: DW] = cur_a[i][t-i];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] model_b(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < K) r[j*DW +: DW] = cur_b[t-j][j];
    return r;
  endfunction

  function automatic logic [M*DW-1:0] pack_a(input int k);
    logic [M*DW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[i*DW +: DW] = cur_a[i][k];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = cur_b[k][j];
    return r;
  endfunction

  function automatic logic [31:0] exp_tile_count();
`ifdef FEEDER_TILE_CNT_EN
    return 32'(tiles_done);
`else
    return 32'd0;
`endif
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name, input logic exp_ready);
    check({name, "_a_out"}, 64'(a_out), 64'd0);
    check({name, "_b_out"}, 64'(b_out), 64'd0);
    check({name, "_acc_clr"}, 64'(acc_clr), 64'd0);
    check({name, "_feed_active"}, 64'(feed_active), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
  endtask

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_directed();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) cur_a[i][k] = 16'(4*i + k + 1);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) cur_b[k][j] = 16'(16 + 4*k + j);
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) cur_a[i][k] = 16'($urandom);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) cur_b[k][j] = 16'($urandom);
  endtask

  // mode 0: back-to-back beats, 1: valid pattern 1,0,0,1,1,0,1, 2: random valid
  task automatic run_tile(input int mode, input bit hold, input int abort_t, input bit record);
    bit pat [7];
    int k, budget, p;
    bit v, acc;
    logic [M*DW-1:0] ea;
    logic [N*DW-1:0] eb;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    k = 0; budget = 0; p = 0;
    while (k < K && budget < 64) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = pat[p % 7]; p++; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_a = v ? pack_a(k) : {$urandom, $urandom};
      in_b = v ? pack_b(k) : {$urandom, $urandom};
      check_quiet("load", 1'b1);
      acc = v && in_ready;
      step();
      if (acc) k++;
      budget++;
    end
    if (k < K) begin
      check("load_budget", 64'(k), 64'(K));
      in_valid = 1'b0;
      return;
    end
    for (int t = 0; t < T; t++) begin
      exp_q.push_back(model_a(t));
      exp_b_q.push_back(model_b(t));
    end
    in_valid = hold;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    check("clr_acc_clr", 64'(acc_clr), 64'd1);
    check("clr_in_ready", 64'(in_ready), 64'd0);
    check("clr_feed_active", 64'(feed_active), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_a_out", 64'(a_out), 64'd0);
    check("clr_b_out", 64'(b_out), 64'd0);
    step();
    for (int t = 0; t < T; t++) begin
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      ea = exp_q.pop_front();
      eb = exp_b_q.pop_front();
      check($sformatf("feed_t%0d_a_out", t), 64'(a_out), 64'(ea));
      check($sformatf("feed_t%0d_b_out", t), 64'(b_out), 64'(eb));
      check($sformatf("feed_t%0d_feed_active", t), 64'(feed_active), 64'd1);
      check($sformatf("feed_t%0d_in_ready", t), 64'(in_ready), 64'd0);
      check($sformatf("feed_t%0d_acc_clr", t), 64'(acc_clr), 64'd0);
      check($sformatf("feed_t%0d_done", t), 64'(done), 64'd0);
      if (record) begin
        seen_a[t] = a_out;
        seen_b[t] = b_out;
      end
      if (t == abort_t) begin
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_quiet("abort", 1'b1);
        check("abort_tile_count", 64'(tile_count), 64'(exp_tile_count()));
        exp_q.delete();
        exp_b_q.delete();
        step();
        rst = 1'b0;
        check_quiet("abort_release", 1'b1);
        step();
        check_quiet("after_abort", 1'b1);
        return;
      end
      step();
    end
    check("done_done", 64'(done), 64'd1);
    check("done_a_out", 64'(a_out), 64'd0);
    check("done_b_out", 64'(b_out), 64'd0);
    check("done_in_ready", 64'(in_ready), 64'd0);
    check("done_feed_active", 64'(feed_active), 64'd0);
    check("done_acc_clr", 64'(acc_clr), 64'd0);
    step();
    tiles_done++;
    in_valid = 1'b0;
    check_quiet("reload", 1'b1);
    check("tile_count", 64'(tile_count), 64'(exp_tile_count()));
  endtask

  initial begin
    vecs[0] = '{t: 0, a: 64'h0000_0000_0000_0001, b: 64'h0000_0000_0000_0010};
    vecs[1] = '{t: 1, a: 64'h0000_0000_0005_0002, b: 64'h0000_0000_0011_0014};
    vecs[2] = '{t: 3, a: 64'h000d_000a_0007_0004, b: 64'h0013_0016_0019_001c};
    vecs[3] = '{t: 6, a: 64'h0010_0000_0000_0000, b: 64'h001f_0000_0000_0000};
    vecs[4] = '{t: 9, a: 64'h0000_0000_0000_0000, b: 64'h0000_0000_0000_0000};

    rst = 1'b1;
    in_valid = 1'b1;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    repeat (3) begin
      step();
      check_quiet("reset", 1'b1);
      check("reset_tile_count", 64'(tile_count), 64'd0);
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check_quiet("post_reset", 1'b1);

    fill_directed();
    run_tile(0, 1'b0, -1, 1'b1);
    for (int v = 0; v < 5; v++) begin
      check($sformatf("vec_t%0d_a_out", vecs[v].t), 64'(seen_a[vecs[v].t]), vecs[v].a);
      check($sformatf("vec_t%0d_b_out", vecs[v].t), 64'(seen_b[vecs[v].t]), vecs[v].b);
    end

    fill_random();
    run_tile(1, 1'b1, -1, 1'b0);

    fill_random();
    run_tile(0, 1'b0, 5, 1'b0);

    fill_random();
    run_tile(0, 1'b0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_tile(2, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
